// File: rtl/scan_link_arbiter.sv
// scan_link_arbiter: round-robin arbiter that shares one serial link between two scanners,
// forwarding the owner's serial clock/data and flagging completion, drop or timeout.
module scan_link_arbiter #(
  parameter int N_BITS  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] ser_clk_in,
  input  logic [1:0] ser_data_in,
  output logic [1:0] gnt,
  output logic       link_clk,
  output logic       link_data,
  output logic       link_busy,
  output logic       xfer_done,
  output logic       xfer_err,
  output logic [1:0] ps
);
  localparam int BW = $clog2(N_BITS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, XFER = 2'b10, RELEASE = 2'b11} state_t;
  state_t        r_state;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_prev_clk;
  logic [BW-1:0] r_bits;
  logic [IW-1:0] r_idle;
  logic [1:0]    r_gnt;
  logic          r_link_clk;
  logic          r_link_data;
  logic          r_done;
  logic          r_err;
  logic          w_src_clk;
  logic          w_src_data;
  logic          w_edge;
  logic          w_timeout;
  logic          w_full;
  logic [BW-1:0] w_bits_nx;
  logic [IW-1:0] w_idle_nx;

  assign w_src_clk  = ser_clk_in[r_owner];
  assign w_src_data = ser_data_in[r_owner];
  assign w_edge     = w_src_clk & ~r_prev_clk;
  assign w_bits_nx  = r_bits + BW'(w_edge);
  // idle counter saturates at TIMEOUT so it can never wrap back to a small value
  assign w_idle_nx  = w_edge ? '0 : (r_idle == IW'(TIMEOUT)) ? r_idle : r_idle + IW'(1);
  assign w_timeout  = w_idle_nx == IW'(TIMEOUT);
  assign w_full     = w_bits_nx == BW'(N_BITS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_prev_clk   <= 1'b0;
      r_bits       <= '0;
      r_idle       <= '0;
      r_gnt        <= 2'b00;
      r_link_clk   <= 1'b0;
      r_link_data  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_owner <= (req == 2'b11) ? ~r_last_owner : req[1];
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_gnt       <= r_owner ? 2'b10 : 2'b01;
          r_bits      <= '0;
          r_idle      <= '0;
          r_prev_clk  <= w_src_clk;
          r_link_clk  <= w_src_clk;
          r_link_data <= w_src_data;
          r_state     <= XFER;
        end
        XFER: begin
          r_link_clk  <= w_src_clk;
          r_link_data <= w_src_data;
          r_prev_clk  <= w_src_clk;
          r_bits      <= w_bits_nx;
          r_idle      <= w_idle_nx;
          // a dropped request or timeout wins over a completion in the same cycle
          if (!req[r_owner] || w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RELEASE;
          end else if (w_full) begin
            r_done  <= 1'b1;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_gnt        <= 2'b00;
          r_link_clk   <= 1'b0;
          r_link_data  <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign link_clk  = r_link_clk;
  assign link_data = r_link_data;
  assign link_busy = (r_state == GRANT) || (r_state == XFER);
  assign xfer_done = r_done;
  assign xfer_err  = r_err;
  assign ps        = r_state;
endmodule

// File: doc/scan_link_arbiter.md
Name: scan_link_arbiter

Overview:
- Shares one serial transfer link between two scanner units. Each scanner raises a request when its buffer is ready to send.
- Grants the link to one scanner at a time using round-robin order, and forwards the granted scanner's serial clock and data onto the link.
- Counts transferred bits, flags completion or error, and exposes its state code for the bench.
- Sits between the scanner pair and the inter-scanner link; the gnt bits drive each scanner's readyForTransferIn.

Parameters:
- N_BITS, 8: serial clock rising edges that make up one complete transfer.
- TIMEOUT, 32: maximum consecutive cycles in XFER without a serial-clock rising edge before the transfer is aborted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  2  req[i]=1: scanner i requests the link; held high until its transfer ends.
- ser_clk_in  input  2  serial clock from scanner i.
- ser_data_in  input  2  serial data from scanner i.
- gnt  output  2  one-hot grant (or 0); drives scanner i readyForTransferIn.
- link_clk  output  1  registered copy of the granted scanner's ser_clk_in.
- link_data  output  1  registered copy of the granted scanner's ser_data_in.
- link_busy  output  1  high in GRANT and XFER.
- xfer_done  output  1  one-cycle pulse on successful completion.
- xfer_err  output  1  one-cycle pulse on abort (request dropped or timeout).
- ps  output  2  state code: IDLE=00, GRANT=01, XFER=10, RELEASE=11.

Behaviour:
- Reset (rst=0, asynchronous):
  - ps=IDLE; gnt=00; link_clk=link_data=0; link_busy=0; xfer_done=xfer_err=0.
  - Bit counter=0, idle counter=0, owner=0, last_owner=1, so scanner 0 wins the first tie.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req bit set: owner=that index; next state GRANT.
  - Both set: owner=~last_owner.
- GRANT (1 cycle):
  - gnt[owner]=1, registered (visible the cycle after ps=GRANT is entered).
  - Bit counter and idle counter cleared; edge-detect register loaded with ser_clk_in[owner].
  - Next state XFER.
- XFER:
  - link_clk/link_data = ser_clk_in[owner]/ser_data_in[owner], delayed exactly one clk.
  - Rising edge of ser_clk_in[owner] (sampled 0 then 1): bit counter +1, idle counter cleared.
  - No edge: idle counter +1.
  - Exits, evaluated in priority order:
    - req[owner]=0: RELEASE, xfer_err pulse.
    - Idle counter reaches TIMEOUT: RELEASE, xfer_err pulse.
    - Bit counter reaches N_BITS: RELEASE, xfer_done pulse.
  - If the N_BITS-th edge and a req drop occur in the same cycle, the result is error; done is not pulsed.
  - Requests from the non-owner are ignored until the next IDLE.
- RELEASE (1 cycle):
  - gnt=00, link_clk=link_data=0, link_busy=0, last_owner=owner.
  - Next state IDLE.
- Latency:
  - req to gnt: 2 cycles (IDLE→GRANT, then registered gnt).
  - Back-to-back transfers: gnt low for at least 2 cycles between owners.
- Non-owner signals: link outputs never reflect the non-owner's ser_clk_in/ser_data_in.
- Widths:
  - Bit counter width = clog2(N_BITS+1).
  - Idle counter width = clog2(TIMEOUT+1); saturates, never wraps.
- Reset mid-transfer: immediate return to reset values; no done or err pulse.
- Invariant: gnt is never 11; xfer_done and xfer_err are never high together.

Test Plan:
- Reset held 3 cycles, then released with req=00 for 5 cycles -> ps=00, gnt=00, all outputs 0 throughout.
- req=01; scanner 0 toggles ser_clk_in[0] 8 times (period 4) with data 10110010 -> gnt=01 two cycles after req, link_data shows 10110010 one cycle after the source, one xfer_done pulse, ps sequence 00→01→10→11→00.
- req=11 from reset -> scanner 0 served first. After done with req=11 held, scanner 1 granted next. A third request from both -> scanner 0 again.
- Granted scanner 1 drops req after 3 edges -> xfer_err pulse, gnt=00 next cycle, no xfer_done.
- Granted scanner holds ser_clk_in constant for 32 cycles -> xfer_err on the timeout cycle, ps 10→11→00.
- rst asserted during XFER after 4 bits -> ps=00, gnt=00 immediately (asynchronous); after release with req still high, a fresh grant occurs and the bit count restarts at 0.
